kv_req_parser: RTL and testbench
================================

// Module: kv_req_parser
// PURPOSE
//  Ingress stage directly upstream of the KV key-lookup stage. Parses raw request packets from the RX queues
//  (512-bit AXIS, 1-2 beats) into single-beat lookup requests with the sideband tuser layout the lookup stage consumes.
//  Drops malformed packets in full (drain to tlast) and counts accepted and dropped packets.
// PARAMETERS
//  C_S_AXIS_DATA_WIDTH   512  input data width; header fields are fixed in the low 80 bits
//  C_M_AXIS_DATA_WIDTH   512  output data width; must equal C_S_AXIS_DATA_WIDTH
//  C_S_AXIS_TUSER_WIDTH  128  input tuser width; input tuser is ignored
//  C_M_AXIS_TUSER_WIDTH  128  output tuser width; must be >= 80
//  C_S_AXIS_TDEST_WIDTH  3    input tdest width
//  C_M_AXIS_TDEST_WIDTH  3    output tdest width
// PORTS
//  axis_aclk      in   1      clock
//  axis_resetn    in   1      reset, asynchronous assert, active-low
//  s_axis_tdata   in   512    request beats
//  s_axis_tkeep   in   64     ignored
//  s_axis_tuser   in   128    ignored
//  s_axis_tdest   in   3      captured from the header beat
//  s_axis_tvalid  in   1      input valid
//  s_axis_tready  out  1      input ready
//  s_axis_tlast   in   1      last beat of the packet
//  m_axis_tdata   out  512    value payload for SET; 0 for GET
//  m_axis_tkeep   out  64     always all-ones
//  m_axis_tuser   out  128    [47:0] key tag; [48] opcode (1 = SET); [63:56] src_node; [79:64] length; all other bits 0
//  m_axis_tdest   out  3      header-beat tdest
//  m_axis_tvalid  out  1      output valid
//  m_axis_tready  in   1      output ready
//  m_axis_tlast   out  1      constant 1
//  stat_pkt_ok    out  32     count of emitted requests
//  stat_pkt_drop  out  32     count of dropped packets
// BEHAVIOUR
//  Header beat fields: tdata[7:0] opcode (8'h00 = GET, 8'h01 = SET); [15:8] src_node; [31:16] length in bytes; [79:32] key tag.
//  FSM states: HDR (reset state), VAL, DRAIN.
//   HDR, GET with tlast=1: load output register, length = 0, tdata = 0. State stays HDR.
//   HDR, SET with tlast=0 and length 1..64: latch the header fields, go to VAL.
//   HDR, any other case (bad opcode; GET with tlast=0; SET with tlast=1; SET with length 0 or >64):
//    count one drop. Go to DRAIN if tlast=0, otherwise stay in HDR.
//   VAL, tlast=1: load output register with the latched header fields and tdata = this beat. Go to HDR.
//   VAL, tlast=0: count one drop. Go to DRAIN. Nothing is emitted.
//   DRAIN: discard beats; go to HDR on the tlast beat.
//  Output register: one entry, registered (no combinational s->m path).
//   Input-to-output latency is 1 cycle after the completing beat.
//   m_axis_tvalid stays high with stable data until m_axis_tready is sampled high.
//  s_axis_tready = (state==DRAIN) | !m_axis_tvalid | m_axis_tready.
//   Load and drain may occur in the same cycle; in that case the new entry replaces the old one.
//  Counters: stat_pkt_ok increments on a completed output handshake. stat_pkt_drop increments on the drop decision.
//   Both wrap at 2^32. A drop and an ok handshake in the same cycle both count.
//  Reset values: m_axis_tvalid = 0; tdata, tuser and tdest = 0; counters = 0; state = HDR.
//   If reset hits mid-packet, the packet is lost uncounted; the first beat after reset is parsed as a header.
// CONFIGURATION
//  KV_PARSER_STATS_EN defined: stat counters are implemented as specified above.
//  KV_PARSER_STATS_EN undefined: stat_pkt_ok and stat_pkt_drop are tied to 32'h0 and no counter flops exist.
//   Datapath behaviour is identical with or without the macro.
// STRUCTURE
//  Package kv_pkg holds:
//   opcode constants KV_OP_GET and KV_OP_SET;
//   header field offsets and widths;
//   output tuser field offsets (KEY[47:0], OP 48, SRC[63:56], LEN[79:64]), shared with the lookup stage;
//   KV_MAX_VAL_BYTES = 64;
//   FSM state enum.
//  Sub-module kv_hdr_decode: combinational; tdata -> {opcode_ok, is_set, src_node, length, key_tag, len_ok}.
// TESTING
//  GET, 1 beat: opcode 0, src 8'h05, key 48'hA1B2C3D4E5F6, tdest 2
//   -> one output: tuser[47:0]=A1B2C3D4E5F6, [48]=0, [63:56]=05, [79:64]=0; tdata=0; tdest=2; stat_pkt_ok=1.
//  SET, 2 beats: length 16'd40, value beat 512'hDEAD...BEEF
//   -> output tdata = value beat, tuser[48]=1, [79:64]=40; emitted 1 cycle after the value beat.
//  Malformed packets:
//   opcode 8'h07, 3 beats -> no output; stat_pkt_drop=1; all 3 beats accepted.
//   SET with length 65 -> dropped.
//   GET with tlast=0 -> dropped and drained.
//  Backpressure: m_axis_tready low for 10 cycles during a stream of 4 GETs
//   -> output held stable; s_axis_tready low while full; all 4 emitted in order with no loss.
//  Reset mid-SET (after header, before value beat) -> m_axis_tvalid=0 and counters=0;
//   the next GET is parsed and emitted correctly.
//  Build with KV_PARSER_STATS_EN undefined -> stat outputs read 0; output stream identical to the stats build.

Source files
------------

// File: rtl/kv_req_parser_pkg.sv
// Shared constants, header/tuser layouts and FSM state encoding for the KV request parser.
// The tuser layout is also consumed by the downstream key-lookup stage.
package kv_pkg;

  localparam logic [7:0] KV_OP_GET = 8'h00;
  localparam logic [7:0] KV_OP_SET = 8'h01;

  localparam int HDR_OP_LSB  = 0;
  localparam int HDR_OP_W    = 8;
  localparam int HDR_SRC_LSB = 8;
  localparam int HDR_SRC_W   = 8;
  localparam int HDR_LEN_LSB = 16;
  localparam int HDR_LEN_W   = 16;
  localparam int HDR_KEY_LSB = 32;
  localparam int HDR_KEY_W   = 48;
  localparam int HDR_W       = 80;

  localparam int TU_KEY_LSB = 0;
  localparam int TU_OP_BIT  = 48;
  localparam int TU_SRC_LSB = 56;
  localparam int TU_LEN_LSB = 64;
  localparam int TU_W       = 80;

  localparam int KV_MAX_VAL_BYTES = 64;

  // Packed MSB-first, so field positions line up with the offsets above.
  typedef struct packed {
    logic [HDR_KEY_W-1:0] key;
    logic [HDR_LEN_W-1:0] len;
    logic [HDR_SRC_W-1:0] src;
    logic [HDR_OP_W-1:0]  op;
  } kv_hdr_t;

  typedef struct packed {
    logic [15:0] len;
    logic [7:0]  src;
    logic [6:0]  rsvd;
    logic        is_set;
    logic [47:0] key;
  } kv_tuser_t;

  typedef enum logic [1:0] {
    ST_HDR,
    ST_VAL,
    ST_DRAIN
  } kv_state_e;

endpackage

// File: rtl/kv_req_parser_if.sv
// AXI-Stream bundle used on both sides of the KV request parser.
// master drives the payload and valid; slave drives ready.
interface kv_req_parser_if #(
  parameter int DATA_W  = 512,
  parameter int TUSER_W = 128,
  parameter int TDEST_W = 3
);
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic [TUSER_W-1:0]  tuser;
  logic [TDEST_W-1:0]  tdest;
  logic                tvalid;
  logic                tready;
  logic                tlast;

  modport master (output tdata, tkeep, tuser, tdest, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tuser, tdest, tvalid, tlast, output tready);
endinterface

// File: rtl/kv_req_parser_hdr_decode.sv
// Header-beat field extraction and validity checks; purely combinational, no backpressure.
module kv_hdr_decode
  import kv_pkg::*;
(
  input  logic [HDR_W-1:0]     hdr_i,
  output logic                 opcode_ok_o,
  output logic                 is_set_o,
  output logic [HDR_SRC_W-1:0] src_node_o,
  output logic [HDR_LEN_W-1:0] length_o,
  output logic [HDR_KEY_W-1:0] key_tag_o,
  output logic                 len_ok_o
);
  kv_hdr_t hdr;

  assign hdr         = hdr_i;
  assign opcode_ok_o = (hdr.op == KV_OP_GET) || (hdr.op == KV_OP_SET);
  assign is_set_o    = (hdr.op == KV_OP_SET);
  assign src_node_o  = hdr.src;
  assign length_o    = hdr.len;
  assign key_tag_o   = hdr.key;
  // A SET value must fit in the single output beat.
  assign len_ok_o    = (hdr.len != '0) && (hdr.len <= HDR_LEN_W'(KV_MAX_VAL_BYTES));
endmodule

// File: rtl/kv_req_parser.sv
// Parses 1-2 beat KV requests into single-beat lookup requests; 1-cycle registered output, drops malformed packets.
// Input stalls only while the output register is full and not draining; macro KV_PARSER_STATS_EN enables counters.
module kv_req_parser
  import kv_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = 512,
  parameter int C_M_AXIS_DATA_WIDTH  = 512,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TDEST_WIDTH = 3,
  parameter int C_M_AXIS_TDEST_WIDTH = 3
) (
  input  logic                   axis_aclk,
  input  logic                   axis_resetn,
  kv_req_parser_if.slave         s_axis,
  kv_req_parser_if.master        m_axis,
  output logic [31:0]            stat_pkt_ok,
  output logic [31:0]            stat_pkt_drop
);
  kv_state_e state_q, state_d;

  logic                            vld_q, vld_d;
  logic [C_M_AXIS_DATA_WIDTH-1:0]  dat_q, dat_d;
  logic [C_M_AXIS_TUSER_WIDTH-1:0] user_q, user_d;
  logic [C_M_AXIS_TDEST_WIDTH-1:0] dest_q, dest_d;

  logic [HDR_KEY_W-1:0]            key_q, key_d;
  logic [HDR_SRC_W-1:0]            src_q, src_d;
  logic [HDR_LEN_W-1:0]            len_q, len_d;
  logic [C_M_AXIS_TDEST_WIDTH-1:0] hdest_q, hdest_d;

  logic                 dec_opcode_ok, dec_is_set, dec_len_ok;
  logic [HDR_SRC_W-1:0] dec_src;
  logic [HDR_LEN_W-1:0] dec_len;
  logic [HDR_KEY_W-1:0] dec_key;

  logic      s_rdy, beat, drop, m_hs;
  kv_tuser_t tu;

  kv_hdr_decode u_dec (
    .hdr_i       (s_axis.tdata[HDR_W-1:0]),
    .opcode_ok_o (dec_opcode_ok),
    .is_set_o    (dec_is_set),
    .src_node_o  (dec_src),
    .length_o    (dec_len),
    .key_tag_o   (dec_key),
    .len_ok_o    (dec_len_ok)
  );

  assign s_rdy = (state_q == ST_DRAIN) || !vld_q || m_axis.tready;
  assign beat  = s_axis.tvalid && s_rdy;
  assign m_hs  = vld_q && m_axis.tready;

  always_comb begin
    state_d = state_q;
    vld_d   = vld_q && !m_axis.tready;
    dat_d   = dat_q;
    user_d  = user_q;
    dest_d  = dest_q;
    key_d   = key_q;
    src_d   = src_q;
    len_d   = len_q;
    hdest_d = hdest_q;
    drop    = 1'b0;
    tu      = '0;

    unique case (state_q)
      ST_HDR: begin
        if (beat) begin
          if (dec_opcode_ok && !dec_is_set && s_axis.tlast) begin
            tu.key  = dec_key;
            tu.src  = dec_src;
            vld_d   = 1'b1;
            dat_d   = '0;
            user_d  = C_M_AXIS_TUSER_WIDTH'(tu);
            dest_d  = s_axis.tdest;
          end else if (dec_opcode_ok && dec_is_set && !s_axis.tlast && dec_len_ok) begin
            key_d   = dec_key;
            src_d   = dec_src;
            len_d   = dec_len;
            hdest_d = s_axis.tdest;
            state_d = ST_VAL;
          end else begin
            drop    = 1'b1;
            state_d = s_axis.tlast ? ST_HDR : ST_DRAIN;
          end
        end
      end
      ST_VAL: begin
        if (beat) begin
          if (s_axis.tlast) begin
            tu.key    = key_q;
            tu.src    = src_q;
            tu.len    = len_q;
            tu.is_set = 1'b1;
            vld_d     = 1'b1;
            dat_d     = s_axis.tdata;
            user_d    = C_M_AXIS_TUSER_WIDTH'(tu);
            dest_d    = hdest_q;
            state_d   = ST_HDR;
          end else begin
            drop    = 1'b1;
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (beat && s_axis.tlast) begin
          state_d = ST_HDR;
        end
      end
      default: state_d = ST_HDR;
    endcase
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state_q <= ST_HDR;
      vld_q   <= 1'b0;
      dat_q   <= '0;
      user_q  <= '0;
      dest_q  <= '0;
      key_q   <= '0;
      src_q   <= '0;
      len_q   <= '0;
      hdest_q <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      dat_q   <= dat_d;
      user_q  <= user_d;
      dest_q  <= dest_d;
      key_q   <= key_d;
      src_q   <= src_d;
      len_q   <= len_d;
      hdest_q <= hdest_d;
    end
  end

  assign s_axis.tready = s_rdy;
  assign m_axis.tvalid = vld_q;
  assign m_axis.tdata  = dat_q;
  assign m_axis.tuser  = user_q;
  assign m_axis.tdest  = dest_q;
  assign m_axis.tkeep  = '1;
  assign m_axis.tlast  = 1'b1;

  logic unused_in;
  assign unused_in = ^{s_axis.tkeep, s_axis.tuser};

`ifdef KV_PARSER_STATS_EN
  logic [31:0] ok_q, ok_d;
  logic [31:0] drop_q, drop_d;

  assign ok_d   = m_hs ? ok_q + 32'd1 : ok_q;
  assign drop_d = drop ? drop_q + 32'd1 : drop_q;

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      ok_q   <= '0;
      drop_q <= '0;
    end else begin
      ok_q   <= ok_d;
      drop_q <= drop_d;
    end
  end

  assign stat_pkt_ok   = ok_q;
  assign stat_pkt_drop = drop_q;
`else
  logic unused_stat;
  assign unused_stat   = drop ^ m_hs;
  assign stat_pkt_ok   = 32'h0;
  assign stat_pkt_drop = 32'h0;
`endif

endmodule

// File: tb/tb_kv_req_parser.sv
// Scoreboarded random and directed bench for kv_req_parser; expectations come from packet-level parsing rules.
module tb_kv_req_parser;
  logic axis_aclk   = 1'b0;
  logic axis_resetn = 1'b0;
  logic bp          = 1'b0;
  logic [31:0] stat_ok, stat_drop;

  always #5 axis_aclk = ~axis_aclk;

  kv_req_parser_if s_if ();
  kv_req_parser_if m_if ();

  kv_req_parser dut (
    .axis_aclk     (axis_aclk),
    .axis_resetn   (axis_resetn),
    .s_axis        (s_if.slave),
    .m_axis        (m_if.master),
    .stat_pkt_ok   (stat_ok),
    .stat_pkt_drop (stat_drop)
  );

  typedef struct {
    logic [511:0] d;
    logic [127:0] u;
    logic [2:0]   t;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;
  int exp_ok   = 0;
  int exp_drop = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    m_if.tready = 1'b0;
    forever begin
      @(posedge axis_aclk);
      #1;
      m_if.tready = bp ? 1'b0 : ($urandom_range(3) != 0);
    end
  end

  // Monitor: scoreboard pops on each output handshake; a stalled output must stay put.
  logic         held = 1'b0;
  logic [511:0] hd;
  logic [127:0] hu;
  logic [2:0]   ht;
  always @(negedge axis_aclk) begin
    if (!axis_resetn) begin
      held = 1'b0;
    end else begin
      if (held) begin
        chk("hold_vld", m_if.tvalid, 1'b1);
        chk("hold_dat", m_if.tdata, hd);
        chk("hold_user", m_if.tuser, hu);
        chk("hold_dest", m_if.tdest, ht);
      end
      held = 1'b0;
      if (m_if.tvalid) begin
        if (m_if.tready) begin
          chk("tkeep", m_if.tkeep, {64{1'b1}});
          chk("tlast", m_if.tlast, 1'b1);
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out: got tuser %0h want none", m_if.tuser);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk("out_tdata", m_if.tdata, e.d);
            chk("out_tuser", m_if.tuser, e.u);
            chk("out_tdest", m_if.tdest, e.t);
          end
        end else begin
          held = 1'b1;
          hd = m_if.tdata;
          hu = m_if.tuser;
          ht = m_if.tdest;
        end
      end
    end
  end

  // Called and returns at 1 time unit after a rising edge.
  task automatic send_beat(input logic [511:0] d, input logic [2:0] dst, input logic last);
    int  n;
    logic hs;
    repeat ($urandom_range(1)) begin
      @(posedge axis_aclk);
      #1;
    end
    s_if.tvalid = 1'b1;
    s_if.tdata  = d;
    s_if.tdest  = dst;
    s_if.tlast  = last;
    s_if.tkeep  = {$urandom, $urandom};
    s_if.tuser  = {$urandom, $urandom, $urandom, $urandom};
    n  = 0;
    hs = 1'b0;
    while (!hs && n < 2000) begin
      @(negedge axis_aclk);
      hs = s_if.tready;
      @(posedge axis_aclk);
      #1;
      n++;
    end
    if (!hs) begin
      total++;
      bad++;
      $display("FAIL beat_accept: got no s_axis_tready in %0d cycles want accept", n);
    end
    s_if.tvalid = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] op, input logic [7:0] src, input logic [15:0] len,
                          input logic [47:0] key, input logic [2:0] dst, input int nb,
                          input logic [511:0] val);
    logic [511:0] h;
    exp_t e;
    bit   emit;
    h = rnd512();
    h[79:0] = {key, len, src, op};
    emit = (op == 8'h00 && nb == 1) ||
           (op == 8'h01 && nb == 2 && len >= 16'd1 && len <= 16'd64);
    if (emit) begin
      e.d = (op == 8'h01) ? val : 512'h0;
      e.u = '0;
      e.u[47:0]  = key;
      e.u[48]    = (op == 8'h01);
      e.u[63:56] = src;
      e.u[79:64] = (op == 8'h01) ? len : 16'h0;
      e.t = dst;
      q.push_back(e);
      exp_ok++;
    end else begin
      exp_drop++;
    end
    for (int i = 0; i < nb; i++) begin
      send_beat((i == 0) ? h : ((i == 1) ? val : rnd512()),
                (i == 0) ? dst : 3'($urandom), (i == nb - 1));
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q.size() != 0 || m_if.tvalid) && n < 2000) begin
      @(posedge axis_aclk);
      #1;
      n++;
    end
    if (n >= 2000) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending outputs want 0", q.size());
    end
    repeat (2) @(posedge axis_aclk);
    #1;
  endtask

  task automatic check_stats(input string nm);
`ifdef KV_PARSER_STATS_EN
    chk({nm, "_ok"}, 512'(stat_ok), 512'(exp_ok));
    chk({nm, "_drop"}, 512'(stat_drop), 512'(exp_drop));
`else
    chk({nm, "_ok"}, 512'(stat_ok), 512'h0);
    chk({nm, "_drop"}, 512'(stat_drop), 512'h0);
`endif
  endtask

  task automatic rand_pkt();
    int k;
    logic [7:0]  op;
    logic [15:0] len;
    int nb;
    k   = $urandom_range(7);
    op  = 8'h00;
    len = 16'($urandom);
    nb  = 1;
    case (k)
      0, 1, 2: begin op = 8'h00; nb = 1; end
      3, 4:    begin op = 8'h01; nb = 2; len = 16'($urandom_range(64, 1)); end
      5:       begin op = 8'($urandom_range(255, 2)); nb = $urandom_range(3, 1); end
      6:       begin op = 8'h01; nb = 2; len = ($urandom_range(1) != 0) ? 16'h0 : 16'($urandom_range(65535, 65)); end
      default: begin
        op = 8'($urandom_range(1));
        nb = (op == 8'h00) ? $urandom_range(3, 2) : (($urandom_range(1) != 0) ? 1 : 3);
        len = 16'($urandom_range(64, 1));
      end
    endcase
    send_pkt(op, 8'($urandom), len, {16'($urandom), 32'($urandom)}, 3'($urandom), nb, rnd512());
  endtask

  initial begin
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tkeep  = '0;
    s_if.tuser  = '0;
    s_if.tdest  = '0;
    s_if.tlast  = 1'b0;

    repeat (3) @(negedge axis_aclk);
    chk("rst_tvalid", m_if.tvalid, 1'b0);
    chk("rst_tdata", m_if.tdata, 512'h0);
    chk("rst_tuser", m_if.tuser, 512'h0);
    chk("rst_tdest", m_if.tdest, 512'h0);
    chk("rst_stat_ok", stat_ok, 512'h0);
    chk("rst_stat_drop", stat_drop, 512'h0);
    chk("rst_s_tready", s_if.tready, 1'b1);
    @(posedge axis_aclk);
    #1;
    axis_resetn = 1'b1;
    @(posedge axis_aclk);
    #1;

    send_pkt(8'h00, 8'h05, 16'h1234, 48'hA1B2C3D4E5F6, 3'd2, 1, rnd512());
    chk("get_latency_vld", m_if.tvalid, 1'b1);
    wait_idle();
    check_stats("get1");

    send_pkt(8'h01, 8'h11, 16'd40, 48'h0102030405AA, 3'd5, 2, {16{32'hDEADBEEF}});
    chk("set_latency_vld", m_if.tvalid, 1'b1);
    wait_idle();
    check_stats("set1");

    send_pkt(8'h07, 8'h22, 16'd8, 48'h111111111111, 3'd1, 3, rnd512());
    wait_idle();
    check_stats("badop");

    send_pkt(8'h01, 8'h33, 16'd65, 48'h222222222222, 3'd3, 2, rnd512());
    send_pkt(8'h01, 8'h34, 16'd0, 48'h222222222223, 3'd3, 2, rnd512());
    send_pkt(8'h01, 8'h35, 16'd64, 48'h222222222224, 3'd4, 2, rnd512());
    send_pkt(8'h01, 8'h36, 16'd1, 48'h222222222225, 3'd6, 2, rnd512());
    send_pkt(8'h00, 8'h44, 16'd0, 48'h333333333333, 3'd0, 3, rnd512());
    send_pkt(8'h01, 8'h45, 16'd8, 48'h333333333334, 3'd0, 1, rnd512());
    send_pkt(8'h01, 8'h46, 16'd8, 48'h333333333335, 3'd7, 3, rnd512());
    wait_idle();
    check_stats("bounds");

    bp = 1'b1;
    @(posedge axis_aclk);
    @(posedge axis_aclk);
    #1;
    fork
      begin
        for (int i = 0; i < 4; i++)
          send_pkt(8'h00, 8'(8'h60 + i), 16'h0, 48'(48'hBEEF00 + i), 3'(i), 1, rnd512());
      end
      begin
        repeat (10) @(posedge axis_aclk);
        @(negedge axis_aclk);
        chk("bp_s_tready_low", s_if.tready, 1'b0);
        chk("bp_m_tvalid_high", m_if.tvalid, 1'b1);
        @(posedge axis_aclk);
        #1;
        bp = 1'b0;
      end
    join
    wait_idle();
    check_stats("bp");

    for (int i = 0; i < 150; i++) rand_pkt();
    wait_idle();
    check_stats("rand");

    send_beat({432'h0, 48'h777777777777, 16'd16, 8'h09, 8'h01}, 3'd1, 1'b0);
    axis_resetn = 1'b0;
    @(negedge axis_aclk);
    chk("midrst_tvalid", m_if.tvalid, 1'b0);
    chk("midrst_stat_ok", stat_ok, 512'h0);
    chk("midrst_stat_drop", stat_drop, 512'h0);
    exp_ok   = 0;
    exp_drop = 0;
    @(posedge axis_aclk);
    #1;
    axis_resetn = 1'b1;
    @(posedge axis_aclk);
    #1;
    send_pkt(8'h00, 8'h0A, 16'h0, 48'hCAFEF00D0001, 3'd6, 1, rnd512());
    wait_idle();
    check_stats("postrst");

    chk("scoreboard_empty", 512'(q.size()), 512'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
